io_responder: RTL and testbench
===============================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter: LED_W, 24, LED register width (1..32).
REQ-002 Parameter: SW_W, 24, switch input width (1..32).
REQ-003 Ports:
- clock, input, 1, single clock; all logic on rising edge.
- reset, input, 1, synchronous active-high reset.
REQ-004 IORead, input, 1, IO load request from control unit (address high 22 bits == 0x3FFFFF).
REQ-005 IOWrite, input, 1, IO store request from control unit.
REQ-006 io_addr, input, 10, ALU result bits [9:0], byte offset within IO page.
REQ-007 io_wdata, input, 32, store data.
REQ-008 switch_in, input, SW_W, board switch levels.
REQ-009 io_rdata, output, 32, load data; valid while io_ready=1.
REQ-010 io_ready, output, 1, one-cycle completion strobe.
REQ-011 io_err, output, 1, one-cycle strobe coincident with io_ready on a faulted access.
REQ-012 led_out, output, LED_W, registered LED drive.

Function
REQ-013 Address map (io_addr): 0x060 LED (R/W, low LED_W bits); 0x070 SW (R only, zero-extended switch_in); 0x080 TCNT (R/W, 32-bit timer count); 0x084 TCTRL (R/W, bit0 = run, other bits read 0).
REQ-014 FSM states: IDLE, WAIT, DONE.
REQ-015 Transitions:
- IDLE: goes to DONE when (IORead|IOWrite)=1 and the macro is absent; goes to WAIT when the macro is present.
- WAIT: goes to DONE after its cycle count expires.
- DONE: goes to IDLE unconditionally.
REQ-016 Request qualifiers (io_addr, io_wdata, IORead, IOWrite) are sampled and latched in the IDLE acceptance cycle; later changes are ignored until the access completes.
REQ-017 Completion timing: io_ready=1 for exactly one cycle, in DONE only; io_rdata and io_err are valid in that same cycle and are 0 otherwise.
REQ-018 A request still asserted in the cycle after DONE is accepted as a new access; requesters drop the request in the cycle after io_ready.
REQ-019 Write commit: a write updates its register on the DONE cycle edge; a read samples switch_in or the register in the cycle DONE is entered.
REQ-020 Faulted accesses, all with io_err=1, io_rdata=0 and no register change:
- IORead and IOWrite both set at acceptance;
- unmapped io_addr;
- io_addr[1:0] != 0;
- write to SW.
REQ-021 Timer run behaviour: while TCTRL.run=1, TCNT increments by 1 every cycle; it wraps from 0xFFFFFFFF to 0x00000000.
REQ-022 TCNT write precedence: a TCNT write takes precedence over the increment in the same cycle (loaded value appears next cycle, increment resumes after).
REQ-023 TCTRL write: takes effect on the following cycle.
REQ-024 Writes to LED take the low LED_W bits of io_wdata; upper bits are discarded.

Reset
REQ-025 On reset=1 at a clock edge: FSM goes to IDLE; the following are all 0: led_out, TCNT, TCTRL, io_ready, io_err, io_rdata, the wait counter and latched request fields.
REQ-026 Reset mid-access aborts the access: no io_ready, no register write, no io_err.
REQ-027 Reset dominates all concurrent requests and timer increments.

Configuration
REQ-028 Macro IO_WAIT_STATE_EN:
- Defined: the FSM passes through WAIT for exactly 2 cycles; a request accepted in cycle N gives io_ready in cycle N+3.
- Undefined: WAIT is unreachable; io_ready comes in cycle N+1.
- Register behaviour is identical in both builds.

Verification
REQ-029 Reset, then IOWrite with io_addr=0x060 and io_wdata=0xFFA5A5A5 -> io_ready one cycle at N+1 (N+3 with macro), led_out=0xA5A5A5, io_err=0.
REQ-030 switch_in=0x00F00F, IORead with io_addr=0x070 -> io_rdata=0x0000F00F during io_ready, 0 afterwards.
REQ-031 Write TCNT=0xFFFFFFFE, then TCTRL=1 -> TCNT reads 0xFFFFFFFF then 0x00000000 on consecutive cycles; writing TCNT=0x10 during counting -> next cycle 0x10.
REQ-032 Fault cases, each -> io_ready=1, io_err=1, io_rdata=0, led_out unchanged:
- IORead=IOWrite=1 at io_addr=0x060;
- access to 0x0C0;
- access to 0x062;
- write to 0x070.
REQ-033 IOWrite to 0x060 with reset asserted in the WAIT (macro) or DONE-entry cycle -> no io_ready, led_out=0.
REQ-034 Back-to-back: request held for two accesses -> two io_ready strobes separated by exactly one non-ready cycle (macro off).

Source files
------------

// File: rtl/io_responder_if.sv
// rtl/io_responder_if.sv - request/completion bus between the control unit and the IO responder
interface io_responder_if;
  logic        IORead;
  logic        IOWrite;
  logic [9:0]  io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_ready;
  logic        io_err;

  modport master (
    output IORead, IOWrite, io_addr, io_wdata,
    input  io_rdata, io_ready, io_err
  );

  modport slave (
    input  IORead, IOWrite, io_addr, io_wdata,
    output io_rdata, io_ready, io_err
  );
endinterface

// File: rtl/io_responder.sv
// rtl/io_responder.sv - memory-mapped LED, switch and timer responder with one-cycle completion strobe
// Define IO_WAIT_STATE_EN to insert two wait cycles between acceptance and completion.
module io_responder #(
  parameter int LED_W = 24,
  parameter int SW_W  = 24
) (
  input  logic             clock,
  input  logic             reset,
  io_responder_if.slave    bus,
  input  logic [SW_W-1:0]  switch_in,
  output logic [LED_W-1:0] led_out
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [9:0]        addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wcnt_q, wcnt_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [31:0]       tcnt_q, tcnt_d;
  logic              run_q, run_d;

  logic              hit_led, hit_sw, hit_tcnt, hit_tctrl;
  logic              fault, commit;
  logic [31:0]       led_ext, sw_ext, rd_mux;

  // Decode works only from the latched request so late bus changes cannot alter an access.
  always_comb begin
    hit_led   = (addr_q == 10'h060);
    hit_sw    = (addr_q == 10'h070);
    hit_tcnt  = (addr_q == 10'h080);
    hit_tctrl = (addr_q == 10'h084);
    fault     = (rd_q & wr_q) | (addr_q[1:0] != 2'b00) |
                ~(hit_led | hit_sw | hit_tcnt | hit_tctrl) | (wr_q & hit_sw);
    led_ext              = '0;
    led_ext[LED_W-1:0]   = led_q;
    sw_ext               = '0;
    sw_ext[SW_W-1:0]     = switch_in;
    rd_mux               = '0;
    if (hit_led)        rd_mux = led_ext;
    else if (hit_sw)    rd_mux = sw_ext;
    else if (hit_tcnt)  rd_mux = tcnt_q;
    else if (hit_tctrl) rd_mux = {31'd0, run_q};
  end

  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wcnt_d       = wcnt_q;
    commit       = 1'b0;
    bus.io_ready = 1'b0;
    bus.io_err   = 1'b0;
    bus.io_rdata = '0;
    case (state_q)
      IDLE: begin
        if (bus.IORead | bus.IOWrite) begin
          rd_d    = bus.IORead;
          wr_d    = bus.IOWrite;
          addr_d  = bus.io_addr;
          wdata_d = bus.io_wdata;
`ifdef IO_WAIT_STATE_EN
          state_d = WAIT;
          wcnt_d  = 1'b0;
`else
          state_d = DONE;
`endif
        end
      end
      WAIT: begin
        if (wcnt_q) state_d = DONE;
        else        wcnt_d  = 1'b1;
      end
      DONE: begin
        state_d      = IDLE;
        bus.io_ready = 1'b1;
        bus.io_err   = fault;
        if (!fault && rd_q) bus.io_rdata = rd_mux;
        commit       = !fault && wr_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // A committed TCNT write overrides the free-running increment on the same edge.
  always_comb begin
    led_d  = led_q;
    run_d  = run_q;
    tcnt_d = run_q ? (tcnt_q + 32'd1) : tcnt_q;
    if (commit) begin
      if (hit_led)   led_d  = wdata_q[LED_W-1:0];
      if (hit_tcnt)  tcnt_d = wdata_q;
      if (hit_tctrl) run_d  = wdata_q[0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wcnt_q  <= 1'b0;
      led_q   <= '0;
      tcnt_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wcnt_q  <= wcnt_d;
      led_q   <= led_d;
      tcnt_q  <= tcnt_d;
      run_q   <= run_d;
    end
  end

  assign led_out = led_q;

endmodule

// File: tb/tb_io_responder.sv
// tb/tb_io_responder.sv - directed self-checking bench for io_responder
module tb_io_responder;
`ifdef IO_WAIT_STATE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] switch_in;
  logic [23:0] led_out;

  io_responder_if bus ();

  io_responder #(.LED_W(24), .SW_W(24)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .switch_in (switch_in),
    .led_out   (led_out)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Called just after an edge with the DUT idle; returns just after the edge that leaves DONE.
  task automatic access(input logic rd, input logic wr, input logic [9:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdata,
                        output logic err, output int lat);
    bus.IORead   = rd;
    bus.IOWrite  = wr;
    bus.io_addr  = addr;
    bus.io_wdata = wd;
    lat   = 0;
    rdata = '0;
    err   = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock); #1;
      bus.io_addr  = 10'h000;
      bus.io_wdata = ~wd;
      if (bus.io_ready) begin
        lat = i;
        break;
      end
    end
    rdata = bus.io_rdata;
    err   = bus.io_err;
    bus.IORead  = 1'b0;
    bus.IOWrite = 1'b0;
    @(posedge clock); #1;
  endtask

  typedef struct { logic rd; logic wr; logic [9:0] addr; } fault_vec_t;
  fault_vec_t faults [4];

  logic [31:0] rdata;
  logic        err;
  int          lat;
  int          first_rdy, second_rdy, nrdy;
  logic [31:0] base;

  initial begin
    faults[0] = '{1'b1, 1'b1, 10'h060};
    faults[1] = '{1'b1, 1'b0, 10'h0C0};
    faults[2] = '{1'b0, 1'b1, 10'h062};
    faults[3] = '{1'b0, 1'b1, 10'h070};

    reset = 1'b1;
    bus.IORead = 1'b0; bus.IOWrite = 1'b0; bus.io_addr = '0; bus.io_wdata = '0;
    switch_in = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", {31'd0, bus.io_ready}, 32'd0);
    chk("rst_err",   {31'd0, bus.io_err},   32'd0);
    chk("rst_rdata", bus.io_rdata, 32'd0);
    chk("rst_led",   {8'd0, led_out}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    access(1'b1, 1'b0, 10'h080, 32'd0, rdata, err, lat);
    chk("tcnt_rst", rdata, 32'd0);
    access(1'b1, 1'b0, 10'h084, 32'd0, rdata, err, lat);
    chk("tctrl_rst", rdata, 32'd0);

    access(1'b0, 1'b1, 10'h060, 32'hFFA5A5A5, rdata, err, lat);
    chk("led_wr_lat", lat, LAT);
    chk("led_wr_err", {31'd0, err}, 32'd0);
    chk("led_wr_rdata", rdata, 32'd0);
    chk("led_out", {8'd0, led_out}, 32'h00A5A5A5);

    switch_in = 24'h00F00F;
    access(1'b1, 1'b0, 10'h070, 32'd0, rdata, err, lat);
    chk("sw_rd_lat", lat, LAT);
    chk("sw_rd", rdata, 32'h0000F00F);
    chk("sw_rd_err", {31'd0, err}, 32'd0);
    chk("rdata_idle", bus.io_rdata, 32'd0);
    access(1'b1, 1'b0, 10'h060, 32'd0, rdata, err, lat);
    chk("led_rd", rdata, 32'h00A5A5A5);

    foreach (faults[k]) begin
      access(faults[k].rd, faults[k].wr, faults[k].addr, 32'h12345678, rdata, err, lat);
      chk($sformatf("fault%0d_lat", k), lat, LAT);
      chk($sformatf("fault%0d_err", k), {31'd0, err}, 32'd1);
      chk($sformatf("fault%0d_rdata", k), rdata, 32'd0);
      chk($sformatf("fault%0d_led", k), {8'd0, led_out}, 32'h00A5A5A5);
    end

    // Timer: the count advances once per cycle from the edge after the TCTRL commit.
    access(1'b0, 1'b1, 10'h080, 32'hFFFFFFFE, rdata, err, lat);
    access(1'b0, 1'b1, 10'h084, 32'h00000001, rdata, err, lat);
    base = 32'hFFFFFFFE;
    access(1'b1, 1'b0, 10'h080, 32'd0, rdata, err, lat);
    chk("tcnt_rd1", rdata, base + LAT);
    access(1'b1, 1'b0, 10'h080, 32'd0, rdata, err, lat);
    chk("tcnt_wrap", rdata, base + 2 * LAT + 1);
    access(1'b0, 1'b1, 10'h080, 32'h00000010, rdata, err, lat);
    base = 32'h10;
    access(1'b1, 1'b0, 10'h080, 32'd0, rdata, err, lat);
    chk("tcnt_load", rdata, base + LAT);
    access(1'b1, 1'b0, 10'h084, 32'd0, rdata, err, lat);
    chk("tctrl_run", rdata, 32'd1);
    access(1'b0, 1'b1, 10'h084, 32'hFFFFFFFE, rdata, err, lat);
    access(1'b1, 1'b0, 10'h084, 32'd0, rdata, err, lat);
    chk("tctrl_stop", rdata, 32'd0);
    access(1'b1, 1'b0, 10'h080, 32'd0, rdata, err, lat);
    chk("tcnt_frozen", rdata, base + 3 * LAT + 3);

    // Request held across two accesses.
    first_rdy = 0; second_rdy = 0;
    bus.IORead = 1'b1; bus.io_addr = 10'h070;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clock); #1;
      if (bus.io_ready) begin
        if (first_rdy == 0) first_rdy = i;
        else begin
          second_rdy = i;
          break;
        end
      end
    end
    bus.IORead = 1'b0;
    @(posedge clock); #1;
    chk("b2b_first", first_rdy, LAT);
    chk("b2b_second", second_rdy, 2 * LAT + 1);

    // Reset lands on the edge that would enter DONE (or mid-WAIT).
    bus.IOWrite = 1'b1; bus.io_addr = 10'h060; bus.io_wdata = 32'h00123456;
`ifdef IO_WAIT_STATE_EN
    @(posedge clock); #1;
`endif
    reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_ready", {31'd0, bus.io_ready}, 32'd0);
    chk("abort_err",   {31'd0, bus.io_err},   32'd0);
    bus.IOWrite = 1'b0;
    reset = 1'b0;
    nrdy = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (bus.io_ready) nrdy++;
    end
    chk("abort_no_ready", nrdy, 0);
    chk("abort_led", {8'd0, led_out}, 32'd0);

    access(1'b0, 1'b1, 10'h060, 32'h00000001, rdata, err, lat);
    chk("recover_led", {8'd0, led_out}, 32'h00000001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
